pu_alu_arb: RTL and testbench

Round-robin arbiter and issue pipeline that shares one pu_alu instance among NUM_REQ requesters (PU thread contexts) inside the processing unit. It accepts operand bundles over per-requester valid/ready handshakes, sends one operation per cycle to the ALU, and returns each result on a single tagged response port with backpressure. Sustained throughput is one operation per clock.

---
 rtl/pu_alu_arb.sv | 183 ++++++++++++++++++
 tb/tb_pu_alu_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_alu_arb.sv
// pu_alu_arb: round-robin arbiter and two-stage issue pipeline sharing one
// integer ALU among NUM_REQ requesters, with a single tagged response port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready is one-hot or 0)
//   req_use_imm, req_imm     second-operand select and immediate, slice i = requester i
//   req_rs1, req_rs2         register operands
//   req_funct3, req_funct5   ALU op select / modifier (funct5[3]: sub / arithmetic shift)
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_data         issuing requester and ALU result
//
// Build options:
//   PU_ALU_ARB_PERF_EN  adds perf_op_cnt (response handshakes) and
//                       perf_stall_cnt (cycles with rsp_valid & !rsp_ready).
//   PU_WIDTH_NBITS      default immediate/result width (32 if not defined).

`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

module pu_alu_arb #(
  parameter int NUM_REQ   = 4,
  parameter int ID_NBITS  = $clog2(NUM_REQ),
  parameter int RF_WIDTH  = 32,
  parameter int IN_WIDTH  = `PU_WIDTH_NBITS,
  parameter int OUT_WIDTH = `PU_WIDTH_NBITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_use_imm,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_imm,
  input  logic [NUM_REQ*RF_WIDTH-1:0]   req_rs1,
  input  logic [NUM_REQ*RF_WIDTH-1:0]   req_rs2,
  input  logic [NUM_REQ*3-1:0]          req_funct3,
  input  logic [NUM_REQ*5-1:0]          req_funct5,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_NBITS-1:0]           rsp_id,
  output logic [OUT_WIDTH-1:0]          rsp_data
`ifdef PU_ALU_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_op_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int SH_NBITS = $clog2(RF_WIDTH);

  logic                 s1_valid;
  logic [ID_NBITS-1:0]  s1_id;
  logic                 s1_use_imm;
  logic [IN_WIDTH-1:0]  s1_imm;
  logic [RF_WIDTH-1:0]  s1_rs1;
  logic [RF_WIDTH-1:0]  s1_rs2;
  logic [2:0]           s1_funct3;
  logic [4:0]           s1_funct5;

  logic                 s2_valid;
  logic [ID_NBITS-1:0]  s2_id;
  logic [OUT_WIDTH-1:0] s2_data;

  logic [ID_NBITS-1:0]  rr_ptr;
  logic [ID_NBITS-1:0]  arb_winner;
  logic [ID_NBITS-1:0]  scan_idx;
  logic                 arb_found;
  logic                 accept;
  logic                 s1_adv;
  logic                 s2_adv;

  logic [RF_WIDTH-1:0]  alu_b;
  logic [RF_WIDTH-1:0]  alu_res;
  logic [SH_NBITS-1:0]  shamt;

  // Only the sub/arith-shift bit of funct5 affects this ALU.
  logic                 unused_funct5;
  assign unused_funct5 = ^{s1_funct5[4], s1_funct5[2:0]};

  assign s2_adv = !s2_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = arb_found && s1_adv && !rst;

  // Search starts at rr_ptr; the index is folded back with one subtraction so
  // a non-power-of-two NUM_REQ never reaches an index >= NUM_REQ.
  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr) + k >= NUM_REQ)
        scan_idx = ID_NBITS'(int'(rr_ptr) + k - NUM_REQ);
      else
        scan_idx = ID_NBITS'(int'(rr_ptr) + k);
      if (!arb_found && req_valid[scan_idx]) begin
        arb_found  = 1'b1;
        arb_winner = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[arb_winner] = 1'b1;
  end

  always_comb begin
    alu_b   = s1_use_imm ? RF_WIDTH'($signed(s1_imm)) : s1_rs2;
    shamt   = alu_b[SH_NBITS-1:0];
    alu_res = '0;
    case (s1_funct3)
      3'b000: alu_res = s1_funct5[3] ? (s1_rs1 - alu_b) : (s1_rs1 + alu_b);
      3'b001: alu_res = s1_rs1 << shamt;
      3'b010: alu_res = RF_WIDTH'($signed(s1_rs1) < $signed(alu_b));
      3'b011: alu_res = RF_WIDTH'(s1_rs1 < alu_b);
      3'b100: alu_res = s1_rs1 ^ alu_b;
      3'b101: begin
        if (s1_funct5[3]) alu_res = $unsigned($signed(s1_rs1) >>> shamt);
        else              alu_res = s1_rs1 >> shamt;
      end
      3'b110: alu_res = s1_rs1 | alu_b;
      default: alu_res = s1_rs1 & alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_use_imm <= 1'b0;
      s1_imm     <= '0;
      s1_rs1     <= '0;
      s1_rs2     <= '0;
      s1_funct3  <= '0;
      s1_funct5  <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= '0;
      s2_data    <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (arb_winner == ID_NBITS'(NUM_REQ-1)) ? '0 : arb_winner + 1'b1;
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_id      <= arb_winner;
          s1_use_imm <= req_use_imm[arb_winner];
          s1_imm     <= req_imm[arb_winner*IN_WIDTH +: IN_WIDTH];
          s1_rs1     <= req_rs1[arb_winner*RF_WIDTH +: RF_WIDTH];
          s1_rs2     <= req_rs2[arb_winner*RF_WIDTH +: RF_WIDTH];
          s1_funct3  <= req_funct3[arb_winner*3 +: 3];
          s1_funct5  <= req_funct5[arb_winner*5 +: 5];
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id   <= s1_id;
          s2_data <= OUT_WIDTH'(alu_res);
        end
      end
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_data  = s2_data;

`ifdef PU_ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_op_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (s2_valid && rsp_ready)  perf_op_cnt    <= perf_op_cnt + 32'd1;
      if (s2_valid && !rsp_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pu_alu_arb.sv
module tb_pu_alu_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, req_use_imm;
  logic [N*W-1:0]   req_imm, req_rs1, req_rs2;
  logic [N*3-1:0]   req_funct3;
  logic [N*5-1:0]   req_funct5;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;
`ifdef PU_ALU_ARB_PERF_EN
  logic [31:0]      perf_op_cnt, perf_stall_cnt;
`endif

  pu_alu_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_use_imm(req_use_imm),
    .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct5(req_funct5),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef PU_ALU_ARB_PERF_EN
    , .perf_op_cnt(perf_op_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_m = 0;

  typedef struct { int id; logic [31:0] data; int acc; } item_t;
  item_t q[$];

  logic [N-1:0] s_ready;
  logic         s_rv;
  logic [1:0]   s_id;
  logic [31:0]  s_data;

  typedef struct {
    int          rid;
    logic [2:0]  f3;
    logic [4:0]  f5;
    logic [31:0] rs1, rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [4:0] f5,
                                          input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: return f5[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f5[3] && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, compare with the model, advance model,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_ready;
    logic exp_rv;
    item_t it;
    @(negedge clk);
    s_ready = req_ready; s_rv = rsp_valid; s_id = rsp_id; s_data = rsp_data;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    exp_ready = '0;
    if (!rst && w >= 0 && (q.size() < 2 || rsp_ready)) exp_ready[w] = 1'b1;
    exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 2);
    chk("req_ready", 64'(s_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(s_rv), 64'(exp_rv));
    if (exp_rv && s_rv) begin
      chk("rsp_id", 64'(s_id), 64'(q[0].id));
      chk("rsp_data", 64'(s_data), 64'(q[0].data));
    end
    if (rst) begin
      q.delete();
      rr_m = 0;
    end else begin
      if (exp_rv && rsp_ready) void'(q.pop_front());
      if (exp_ready != 0) begin
        logic [31:0] b;
        b = req_use_imm[w] ? req_imm[w*W +: W] : req_rs2[w*W +: W];
        it.id = w;
        it.data = alu_ref(req_funct3[w*3 +: 3], req_funct5[w*5 +: 5], req_rs1[w*W +: W], b);
        it.acc = cyc;
        q.push_back(it);
        rr_m = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int id, input logic [2:0] f3, input logic [4:0] f5,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic use_imm, input logic [31:0] imm);
    req_funct3[id*3 +: 3] = f3;
    req_funct5[id*5 +: 5] = f5;
    req_rs1[id*W +: W]    = rs1;
    req_rs2[id*W +: W]    = rs2;
    req_use_imm[id]       = use_imm;
    req_imm[id*W +: W]    = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_req(input int id);
    set_req(id, 3'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom), $urandom);
  endtask

  initial begin
    int nacc;
    logic [31:0] held;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    req_use_imm = '0; req_imm = '0; req_rs1 = '0; req_rs2 = '0;
    req_funct3 = '0; req_funct5 = '0;

    vecs[0]  = '{2, 3'b000, 5'b01000, 32'd10,        32'd3,         1'b0, 32'd0,         32'd7};
    vecs[1]  = '{3, 3'b101, 5'b01000, 32'h8000_0000, 32'h0,         1'b1, 32'd4,         32'hF800_0000};
    vecs[2]  = '{0, 3'b000, 5'b00000, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'd0,         32'h8000_0000};
    vecs[3]  = '{1, 3'b100, 5'b00000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'd0,         32'hFF00_FF00};
    vecs[4]  = '{1, 3'b001, 5'b00000, 32'd1,         32'h23,        1'b0, 32'd0,         32'd8};
    vecs[5]  = '{0, 3'b010, 5'b00000, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'd1};
    vecs[6]  = '{0, 3'b011, 5'b00000, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'd0};
    vecs[7]  = '{2, 3'b101, 5'b00000, 32'h8000_0000, 32'd4,         1'b0, 32'd0,         32'h0800_0000};
    vecs[8]  = '{3, 3'b110, 5'b00000, 32'h00FF_0000, 32'h0000_00FF, 1'b0, 32'd0,         32'h00FF_00FF};
    vecs[9]  = '{3, 3'b111, 5'b00000, 32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_0000, 32'h1234_0000};
    vecs[10] = '{0, 3'b000, 5'b01000, 32'd3,         32'd5,         1'b0, 32'd0,         32'hFFFF_FFFE};

    do_reset();
    cycle();
    chk("post_reset_rsp_valid", 64'(s_rv), 64'd0);

    // Table-driven single operations: accept at t, response at t+2.
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].rid, vecs[i].f3, vecs[i].f5, vecs[i].rs1, vecs[i].rs2,
              vecs[i].use_imm, vecs[i].imm);
      req_valid = '0;
      req_valid[vecs[i].rid] = 1'b1;
      cycle();
      chk("tbl_accept", 64'(s_ready), 64'(1) << vecs[i].rid);
      req_valid = '0;
      cycle();
      chk("tbl_early", 64'(s_rv), 64'd0);
      cycle();
      chk("tbl_valid", 64'(s_rv), 64'd1);
      chk("tbl_id", 64'(s_id), 64'(vecs[i].rid));
      chk("tbl_data", 64'(s_data), 64'(vecs[i].exp));
    end

    // All requesters streaming: grants 0,1,2,3,... and ids two cycles later.
    do_reset();
    for (int i = 0; i < N; i++) rand_req(i);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      chk("rr_grant", 64'(s_ready), 64'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_rsp_valid", 64'(s_rv), 64'd1);
        chk("rr_rsp_id", 64'(s_id), 64'((k - 2) % 4));
      end
    end
    req_valid = '0;
    cycle(); cycle();

    // Backpressure with requesters 0 and 1 streaming.
    do_reset();
    req_valid = 4'b0011; rsp_ready = 1'b0; nacc = 0; held = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (s_ready != 0) nacc++;
      if (k == 2) held = s_data;
      if (k >= 2) begin
        chk("bp_ready_zero", 64'(s_ready), 64'd0);
        chk("bp_hold_valid", 64'(s_rv), 64'd1);
        chk("bp_hold_id", 64'(s_id), 64'd0);
        chk("bp_hold_data", 64'(s_data), 64'(held));
      end
    end
    chk("bp_accepts", 64'(nacc), 64'd2);
    rsp_ready = 1'b1;
    cycle();
    chk("bp_resume_grant", 64'(s_ready), 64'b0001);
    chk("bp_out0_id", 64'(s_id), 64'd0);
    req_valid = '0;
    cycle();
    chk("bp_out1_valid", 64'(s_rv), 64'd1);
    chk("bp_out1_id", 64'(s_id), 64'd1);
    cycle();
    chk("bp_out2_id", 64'(s_id), 64'd0);
    cycle();
    chk("bp_drained", 64'(s_rv), 64'd0);

    // Reset with both stages full.
    rsp_ready = 1'b0; req_valid = 4'b1000;
    cycle(); cycle(); cycle();
    rst = 1'b1; req_valid = 4'b0110;
    cycle();
    rst = 1'b0; rsp_ready = 1'b1;
    cycle();
    chk("rst_full_rsp_valid", 64'(s_rv), 64'd0);
    chk("rst_first_grant", 64'(s_ready), 64'b0010);
    req_valid = '0;
    cycle(); cycle(); cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) rand_req(i);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom % 10) < 7;
      rst = ($urandom % 256) == 0;
      cycle();
    end
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    cycle(); cycle(); cycle();

`ifdef PU_ALU_ARB_PERF_EN
    do_reset();
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    cycle(); cycle(); cycle();
    rsp_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("perf_op_cnt", 64'(perf_op_cnt), 64'd10);
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
